// File: rtl/classifier_scheduler.sv
// classifier_scheduler
//   Round-robin scheduler that time-shares one decision-tree classifier among
//   CHANNEL_COUNT spike channels. An eligible channel (req & ch_enable) is
//   granted, launched with a start pulse and then watched until the classifier
//   answers or the watchdog expires. The result, tagged with its channel, is
//   held in a one-entry valid/ready output register.
//
// Ports
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   req, ch_enable    : per-channel level request and eligibility mask
//   grant, start      : one-cycle launch pulses (grant is one-hot)
//   ch_index          : channel being classified, held from LAUNCH through RUN
//   abort             : one-cycle classifier reset after a watchdog expiry
//   busy              : scheduler not idle
//   cls_out_valid, cls_level, cls_path : classifier result strobe and data
//   res_valid/res_ready : output register handshake
//   res_channel, res_level, res_path, res_error : held result
module classifier_scheduler #(
  parameter int CHANNEL_COUNT = 16,
  parameter int FEATURES      = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNEL_COUNT-1:0]         req,
  input  logic [CHANNEL_COUNT-1:0]         ch_enable,
  output logic [CHANNEL_COUNT-1:0]         grant,
  output logic [$clog2(CHANNEL_COUNT)-1:0] ch_index,
  output logic                             start,
  output logic                             abort,
  output logic                             busy,
  input  logic                             cls_out_valid,
  input  logic [$clog2(FEATURES)-1:0]      cls_level,
  input  logic [$clog2(FEATURES)-1:0]      cls_path,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [$clog2(CHANNEL_COUNT)-1:0] res_channel,
  output logic [$clog2(FEATURES)-1:0]      res_level,
  output logic [$clog2(FEATURES)-1:0]      res_path,
  output logic                             res_error
);

  localparam int CW = $clog2(CHANNEL_COUNT);
  localparam int LW = $clog2(FEATURES);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CW-1:0]            r_last;
  logic [WW-1:0]            r_wd;
  logic [CHANNEL_COUNT-1:0] r_grant;
  logic [CW-1:0]            r_ch_index;
  logic                     r_start;
  logic                     r_abort;
  logic                     r_busy;
  logic                     r_res_valid;
  logic [CW-1:0]            r_res_channel;
  logic [LW-1:0]            r_res_level;
  logic [LW-1:0]            r_res_path;
  logic                     r_res_error;

  logic [CHANNEL_COUNT-1:0] w_elig;
  logic                     w_free;
  logic                     w_found;
  logic [CW-1:0]            w_win;
  logic [CHANNEL_COUNT-1:0] w_onehot;
  logic                     w_timeout;
  logic                     w_launch;
  logic                     w_capture;
  logic                     w_expire;

  assign w_elig    = req & ch_enable;
  // The output slot is usable if empty or being drained this very cycle.
  assign w_free    = ~r_res_valid | res_ready;
  assign w_timeout = (r_wd == WW'(TIMEOUT - 1));

  // Round-robin search starting just after the last winner.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= CHANNEL_COUNT; i++) begin
      if (!w_found && w_elig[CW'((int'(r_last) + i) % CHANNEL_COUNT)]) begin
        w_found = 1'b1;
        w_win   = CW'((int'(r_last) + i) % CHANNEL_COUNT);
      end
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found && w_free) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_RUN;
      S_RUN:    if (cls_out_valid || w_timeout) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode; a valid result wins over a coincident watchdog expiry.
  always_comb begin
    w_launch  = (r_state == S_IDLE) && w_found && w_free;
    w_capture = (r_state == S_RUN) && cls_out_valid;
    w_expire  = (r_state == S_RUN) && !cls_out_valid && w_timeout;
  end

  // Registered outputs, arbitration pointer, watchdog and result slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last        <= CW'(CHANNEL_COUNT - 1);
      r_wd          <= '0;
      r_grant       <= '0;
      r_ch_index    <= '0;
      r_start       <= 1'b0;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_channel <= '0;
      r_res_level   <= '0;
      r_res_path    <= '0;
      r_res_error   <= 1'b0;
    end else begin
      r_start <= w_launch;
      r_grant <= w_launch ? w_onehot : '0;
      r_abort <= w_expire;
      r_busy  <= (w_next != S_IDLE);
      if (w_launch) begin
        r_ch_index <= w_win;
        r_last     <= w_win;
      end
      if (r_state == S_LAUNCH)   r_wd <= '0;
      else if (r_state == S_RUN) r_wd <= r_wd + 1'b1;
      if (w_capture) begin
        r_res_valid   <= 1'b1;
        r_res_channel <= r_ch_index;
        r_res_level   <= cls_level;
        r_res_path    <= cls_path;
        r_res_error   <= 1'b0;
      end else if (w_expire) begin
        r_res_valid   <= 1'b1;
        r_res_channel <= r_ch_index;
        r_res_level   <= '0;
        r_res_path    <= '0;
        r_res_error   <= 1'b1;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign grant       = r_grant;
  assign ch_index    = r_ch_index;
  assign start       = r_start;
  assign abort       = r_abort;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign res_channel = r_res_channel;
  assign res_level   = r_res_level;
  assign res_path    = r_res_path;
  assign res_error   = r_res_error;

endmodule

// File: tb/tb_classifier_scheduler.sv
module tb_classifier_scheduler;

  localparam int NCH = 16;
  localparam int CW  = 4;
  localparam int LW  = 2;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] ch_enable = '0;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  ch_index;
  logic           start;
  logic           abort;
  logic           busy;
  logic           cls_out_valid = 1'b0;
  logic [LW-1:0]  cls_level = '0;
  logic [LW-1:0]  cls_path = '0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [CW-1:0]  res_channel;
  logic [LW-1:0]  res_level;
  logic [LW-1:0]  res_path;
  logic           res_error;

  always #5 clk = ~clk;

  classifier_scheduler #(
    .CHANNEL_COUNT(NCH),
    .FEATURES(3),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .ch_enable(ch_enable),
    .grant(grant),
    .ch_index(ch_index),
    .start(start),
    .abort(abort),
    .busy(busy),
    .cls_out_valid(cls_out_valid),
    .cls_level(cls_level),
    .cls_path(cls_path),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_channel(res_channel),
    .res_level(res_level),
    .res_path(res_path),
    .res_error(res_error)
  );

  int total = 0;
  int bad = 0;
  bit auto_pop = 1'b0;
  int g_q[$];

  // Reference model: a job is either being launched, in flight (with a count
  // of classifier cycles spent), or there is none.
  bit             m_launching;
  bit             m_inflight;
  int             m_run_cnt;
  int             m_last;
  logic [NCH-1:0] e_grant;
  logic [CW-1:0]  e_ch_index;
  logic           e_start, e_abort, e_busy;
  logic           e_rv, e_rerr;
  logic [CW-1:0]  e_rch;
  logic [LW-1:0]  e_rlv, e_rpt;

  function automatic int rr_pick(int last, logic [NCH-1:0] elig);
    logic [3:0] ix;
    for (int off = 1; off <= NCH; off++) begin
      ix = 4'((last + off) % NCH);
      if (elig[ix]) return (last + off) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_launching = 1'b0;
    m_inflight  = 1'b0;
    m_run_cnt   = 0;
    m_last      = NCH - 1;
    e_grant = '0; e_ch_index = '0; e_start = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
    e_rv = 1'b0; e_rerr = 1'b0; e_rch = '0; e_rlv = '0; e_rpt = '0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] elig;
    bit accept, loaded;
    elig   = req & ch_enable;
    accept = e_rv && res_ready;
    loaded = 1'b0;
    e_start = 1'b0;
    e_grant = '0;
    e_abort = 1'b0;
    if (m_launching) begin
      m_launching = 1'b0;
      m_inflight  = 1'b1;
      m_run_cnt   = 0;
    end else if (m_inflight) begin
      m_run_cnt++;
      if (cls_out_valid) begin
        e_rv = 1'b1; e_rch = e_ch_index; e_rlv = cls_level; e_rpt = cls_path; e_rerr = 1'b0;
        loaded = 1'b1; m_inflight = 1'b0;
      end else if (m_run_cnt == TMO) begin
        e_rv = 1'b1; e_rch = e_ch_index; e_rlv = '0; e_rpt = '0; e_rerr = 1'b1;
        e_abort = 1'b1; loaded = 1'b1; m_inflight = 1'b0;
      end
    end else if (elig != '0 && (!e_rv || res_ready)) begin
      m_last = rr_pick(m_last, elig);
      e_ch_index = 4'(m_last);
      e_grant[4'(m_last)] = 1'b1;
      e_start = 1'b1;
      m_launching = 1'b1;
    end
    if (accept && !loaded) e_rv = 1'b0;
    e_busy = m_launching || m_inflight;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), 32'(e_grant));
    chk("ch_index", 32'(ch_index), 32'(e_ch_index));
    chk("start", 32'(start), 32'(e_start));
    chk("abort", 32'(abort), 32'(e_abort));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("res_valid", 32'(res_valid), 32'(e_rv));
    chk("res_channel", 32'(res_channel), 32'(e_rch));
    chk("res_level", 32'(res_level), 32'(e_rlv));
    chk("res_path", 32'(res_path), 32'(e_rpt));
    chk("res_error", 32'(res_error), 32'(e_rerr));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    for (int i = 0; i < NCH; i++) if (grant[4'(i)] === 1'b1) g_q.push_back(i);
    if (auto_pop) req = req & ~e_grant;
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  task automatic wait_start(input int bound);
    int n;
    n = 0;
    while (start !== 1'b1 && n < bound) begin
      cyc();
      n++;
    end
    chk("wait_start", 32'(start), 32'd1);
  endtask

  task automatic serve(input int lat, input logic [LW-1:0] lvl, input logic [LW-1:0] pth);
    for (int i = 0; i < lat; i++) cyc();
    cls_out_valid = 1'b1;
    cls_level = lvl;
    cls_path = pth;
    cyc();
    cls_out_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    model_reset();

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);

    // Single request, result three cycles after start, then held
    ch_enable = '1; res_ready = 1'b0; auto_pop = 1'b1;
    req = 16'h0001;
    wait_start(20);
    chk("single_grant", 32'(grant), 32'h0001);
    cyc(); cyc(); cyc();
    cls_out_valid = 1'b1; cls_level = 2'd2; cls_path = 2'd1;
    cyc();
    cls_out_valid = 1'b0;
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_channel", 32'(res_channel), 32'd0);
    chk("single_level", 32'(res_level), 32'd2);
    chk("single_path", 32'(res_path), 32'd1);
    chk("single_error", 32'(res_error), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Backpressure: channel 1 pending while the result is not accepted
    req = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("bp_no_start", 32'(start), 32'd0);
      chk("bp_hold_level", 32'(res_level), 32'd2);
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    cyc();
    chk("bp_start_after_accept", 32'(start), 32'd1);
    chk("bp_grant", 32'(grant), 32'h0002);
    chk("bp_drained", 32'(res_valid), 32'd0);
    serve(1, 2'd3, 2'd0);
    chk("bp_second_channel", 32'(res_channel), 32'd1);
    chk("bp_second_level", 32'(res_level), 32'd3);

    // Fairness: all channels requesting constantly
    do_reset();
    ch_enable = '1; res_ready = 1'b1; auto_pop = 1'b0; req = '1;
    g_q.delete();
    for (int r = 0; r < 17; r++) begin
      wait_start(40);
      serve(2, 2'(r), 2'(r + 1));
    end
    req = '0;
    chk("fair_count", 32'(g_q.size()), 32'd17);
    for (int j = 0; j < 17 && j < g_q.size(); j++) chk("fair_order", 32'(g_q[j]), 32'(j % NCH));

    // Timeout with a silent classifier, then a late result
    cyc(); cyc();
    auto_pop = 1'b1; res_ready = 1'b0; req = 16'h0001;
    wait_start(20);
    for (int i = 0; i < TMO; i++) cyc();
    chk("tmo_not_yet", 32'(res_valid), 32'd0);
    chk("tmo_still_busy", 32'(busy), 32'd1);
    cyc();
    chk("tmo_valid", 32'(res_valid), 32'd1);
    chk("tmo_error", 32'(res_error), 32'd1);
    chk("tmo_level", 32'(res_level), 32'd0);
    chk("tmo_path", 32'(res_path), 32'd0);
    chk("tmo_abort", 32'(abort), 32'd1);
    cls_out_valid = 1'b1; cls_level = 2'd3; cls_path = 2'd3;
    cyc();
    cls_out_valid = 1'b0;
    chk("late_abort_clear", 32'(abort), 32'd0);
    chk("late_ignored_err", 32'(res_error), 32'd1);
    chk("late_ignored_lvl", 32'(res_level), 32'd0);

    // Valid coincident with the last watchdog cycle
    res_ready = 1'b1; req = 16'h0001;
    wait_start(20);
    for (int i = 0; i < TMO; i++) cyc();
    cls_out_valid = 1'b1; cls_level = 2'd3; cls_path = 2'd2;
    cyc();
    cls_out_valid = 1'b0;
    chk("coin_error", 32'(res_error), 32'd0);
    chk("coin_level", 32'(res_level), 32'd3);
    chk("coin_path", 32'(res_path), 32'd2);
    chk("coin_abort", 32'(abort), 32'd0);

    // Masking: only channel 15 eligible
    ch_enable = 16'h8000; req = '1; auto_pop = 1'b0;
    for (int r = 0; r < 3; r++) begin
      wait_start(20);
      chk("mask_grant", 32'(grant), 32'h8000);
      chk("mask_index", 32'(ch_index), 32'd15);
      serve(1, 2'd1, 2'd1);
    end

    // Reset mid-RUN: in-flight channel 0 discarded, pointer restarts
    ch_enable = '1;
    wait_start(20);
    chk("mid_grant0", 32'(grant), 32'h0001);
    cyc(); cyc();
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_index", 32'(ch_index), 32'd0);
    chk("mid_abort", 32'(abort), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
    wait_start(20);
    chk("mid_first_grant", 32'(grant), 32'h0001);
    serve(1, 2'd0, 2'd0);
    req = '0;

    // Randomized traffic against the model
    do_reset();
    auto_pop = 1'b1; ch_enable = '1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = req | 16'($urandom);
      if ($urandom_range(0, 31) == 0) ch_enable = 16'($urandom) | 16'h0001;
      res_ready = ($urandom_range(0, 2) != 0);
      cls_out_valid = ($urandom_range(0, 5) == 0);
      cls_level = 2'($urandom);
      cls_path = 2'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
